// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states, default
// frame marker and error cause codes used for debug readout.
package uart_prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_W_H,
    ST_W_L,
    ST_WR,
    ST_CHK_H,
    ST_CHK_L,
    ST_DONE,
    ST_RUN,
    ST_ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_LEN,
    ERR_CHK
  } err_cause_e;

  // States in which a stalled byte stream must eventually abort the load.
  function automatic logic tmo_active(input state_e s);
    return s inside {ST_LEN_H, ST_LEN_L, ST_W_H, ST_W_L, ST_WR, ST_CHK_H, ST_CHK_L};
  endfunction

endpackage

// File: rtl/uart_prog_loader_timeout.sv
// Clearable idle down-counter: reloads on clr, counts down while en, tc when
// it reaches zero. No backpressure; tc is a plain level from the register.
module loader_timeout #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_prog_loader.sv
// Assembles big-endian words from UART bytes, writes them to instruction memory
// 1 cycle after the LO byte and releases the CPU once the XOR checksum matches.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [15:0]       uart_inst,
  output logic              uart_inst_en,
  output logic              cpu_enable,
  output logic              load_done,
  output logic              load_err
);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              load_err_q, load_err_d;
  logic [7:0]        skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              run_q, run_d;

  logic              byte_vld;
  logic [7:0]        byte_dat;
  logic [15:0]       len_new;
  logic [16:0]       wcnt_nxt;
  logic              tmo_clr, tmo_en, tmo_tc;

  // A byte parked in the skid register is older than anything on rx_data.
  assign byte_vld = skid_vld_q | rx_valid;
  assign byte_dat = skid_vld_q ? skid_q : rx_data;
  assign len_new  = {len_q[15:8], byte_dat};
  assign wcnt_nxt = 17'(wcnt_q) + 17'd1;

  always_comb begin
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (rx_valid && ((state_q == ST_WR) || skid_vld_q)) begin
      skid_d     = rx_data;
      skid_vld_d = 1'b1;
    end else if (skid_vld_q && (state_q != ST_WR)) begin
      skid_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    acc_d      = acc_q;
    wdata_d    = wdata_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (byte_vld && (byte_dat == SYNC_BYTE)) begin
          state_d    = ST_LEN_H;
          wcnt_d     = '0;
          addr_d     = '0;
          acc_d      = '0;
          load_err_d = 1'b0;
        end
      end
      ST_LEN_H: if (byte_vld) begin
        len_d[15:8] = byte_dat;
        state_d     = ST_LEN_L;
      end
      ST_LEN_L: if (byte_vld) begin
        len_d = len_new;
        if ({1'b0, len_new} > MAX_LEN) state_d = ST_ERR;
        else if (len_new == 16'h0000)  state_d = ST_CHK_H;
        else                           state_d = ST_W_H;
      end
      ST_W_H: if (byte_vld) begin
        hi_d    = byte_dat;
        state_d = ST_W_L;
      end
      ST_W_L: if (byte_vld) begin
        wdata_d = {hi_q, byte_dat};
        state_d = ST_WR;
      end
      ST_WR: begin
        acc_d   = acc_q ^ wdata_q;
        addr_d  = addr_q + ADDR_W'(1);
        wcnt_d  = wcnt_nxt[ADDR_W:0];
        state_d = (wcnt_nxt == {1'b0, len_q}) ? ST_CHK_H : ST_W_H;
      end
      ST_CHK_H: if (byte_vld) begin
        hi_d    = byte_dat;
        state_d = ST_CHK_L;
      end
      ST_CHK_L: if (byte_vld) begin
        state_d = ({hi_q, byte_dat} == acc_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    // WR always completes; a stall is judged again in the following state.
    if (tmo_active(state_q) && (state_q != ST_WR) && !byte_vld && tmo_tc) begin
      state_d = ST_ERR;
    end
    if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      load_err_d = 1'b1;
    end
  end

  assign we_d   = (state_d == ST_WR);
  assign done_d = (state_d == ST_DONE);
  assign run_d  = (state_d == ST_RUN);

  assign tmo_clr = rx_valid | ((state_d == ST_LEN_H) && (state_q != ST_LEN_H));
  assign tmo_en  = tmo_active(state_q);

  loader_timeout #(
    .CYCLES(TIMEOUT_CYC)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .tc   (tmo_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      wdata_q    <= '0;
      load_err_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      wdata_q    <= wdata_d;
      load_err_q <= load_err_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      we_q       <= we_d;
      done_q     <= done_d;
      run_q      <= run_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign uart_inst    = wdata_q;
  assign uart_inst_en = we_q;
  assign cpu_enable   = run_q;
  assign load_done    = done_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a frame-level expectation model.
module tb_uart_prog_loader;
  localparam int         ADDR_W = 8;
  localparam int         TMO    = 40;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         INF    = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [15:0]       uart_inst;
  logic              uart_inst_en;
  logic              cpu_enable;
  logic              load_done;
  logic              load_err;

  uart_prog_loader #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TMO),
    .SYNC_BYTE  (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .uart_inst   (uart_inst),
    .uart_inst_en(uart_inst_en),
    .cpu_enable  (cpu_enable),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int          exp_done[$];
  int          run_start = INF;
  int          run_stop  = INF;
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [15:0] last_data = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the frame-level expectations.
  always @(negedge clk) begin
    if (reset) begin
      chk("inst_en_vs_we", {31'd0, uart_inst_en}, {31'd0, imem_we});
      chk("cpu_enable", {31'd0, cpu_enable},
          {31'd0, (cyc >= run_start) && (cyc < run_stop)});
      if (imem_we) begin
        wr_t e;
        wr_cnt++;
        last_addr = imem_addr;
        last_data = imem_wdata;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected none", imem_addr, imem_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("write_addr", {24'd0, imem_addr}, {24'd0, e.addr});
          chk("write_data", {16'd0, imem_wdata}, {16'd0, e.data});
          chk("uart_inst", {16'd0, uart_inst}, {16'd0, e.data});
        end
      end
      if (load_done) begin
        done_cnt++;
        chk("done_err_low", {31'd0, load_err}, 32'd0);
        if (exp_done.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got load_done=1 at cycle %0d, expected none", cyc);
        end else begin
          chk("done_cycle", cyc, exp_done.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; the byte is sampled at the next edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sync(input int gap);
    if ((cyc + 1 >= run_start) && (run_stop > cyc + 1)) run_stop = cyc + 1;
    send_byte(SYNC, gap);
  endtask

  task automatic send_image(input logic [15:0] w[$], input logic [15:0] chk_word,
                            input int gap, input int skid_at, input int stop_after);
    logic [15:0] x;
    logic [15:0] len;
    wr_t         e;
    x   = 16'h0000;
    len = 16'(w.size());
    send_sync(gap);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    for (int i = 0; i < w.size(); i++) begin
      if (i == stop_after) return;
      send_byte(w[i][15:8], gap);
      e.cyc  = cyc + 1;
      e.addr = 8'(i);
      e.data = w[i];
      exp_wr.push_back(e);
      send_byte(w[i][7:0], (i == skid_at) ? 0 : gap);
      x = x ^ w[i];
    end
    send_byte(chk_word[15:8], gap);
    if (chk_word == x) begin
      exp_done.push_back(cyc + 1);
      run_start = cyc + 2;
      run_stop  = INF;
    end
    send_byte(chk_word[7:0], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
    chk({tag, "_inst"}, {16'd0, uart_inst}, 32'd0);
    chk({tag, "_inst_en"}, {31'd0, uart_inst_en}, 32'd0);
    chk({tag, "_cpu_en"}, {31'd0, cpu_enable}, 32'd0);
    chk({tag, "_done"}, {31'd0, load_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] img_a[$];
    logic [15:0] img[$];
    int w0, d0;
    bit seen;

    img_a.push_back(16'h1234);
    img_a.push_back(16'hABCD);

    idle(3);
    chk_all_reset("rst");
    reset = 1'b1;
    idle(2);

    // Good two-word image, preceded by a stray byte that IDLE must ignore.
    send_byte(8'h00, 2);
    w0 = wr_cnt; d0 = done_cnt;
    send_image(img_a, 16'hB9F9, 1, -1, -1);
    idle(3);
    chk("A_writes", wr_cnt - w0, 2);
    chk("A_done", done_cnt - d0, 1);
    chk("A_last_addr", {24'd0, last_addr}, 32'h1);
    chk("A_last_data", {16'd0, last_data}, 32'hABCD);
    chk("A_cpu_en", {31'd0, cpu_enable}, 32'd1);
    chk("A_err", {31'd0, load_err}, 32'd0);

    // Same image with a corrupted checksum, sent as a reload from RUN.
    w0 = wr_cnt; d0 = done_cnt;
    send_sync(0);
    #1;
    chk("reload_cpu_drop", {31'd0, cpu_enable}, 32'd0);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      send_byte(img_a[i][15:8], 1);
      e.cyc = cyc + 1; e.addr = 8'(i); e.data = img_a[i];
      exp_wr.push_back(e);
      send_byte(img_a[i][7:0], 1);
    end
    send_byte(8'hB9, 1);
    send_byte(8'hF8, 1);
    idle(3);
    chk("bad_writes", wr_cnt - w0, 2);
    chk("bad_done", done_cnt - d0, 0);
    chk("bad_err", {31'd0, load_err}, 32'd1);
    chk("bad_cpu_en", {31'd0, cpu_enable}, 32'd0);

    // Correct image after the error clears load_err and completes.
    d0 = done_cnt;
    send_image(img_a, 16'hB9F9, 1, -1, -1);
    idle(3);
    chk("retry_err", {31'd0, load_err}, 32'd0);
    chk("retry_done", done_cnt - d0, 1);

    // Empty image.
    img.delete();
    w0 = wr_cnt; d0 = done_cnt;
    send_image(img, 16'h0000, 1, -1, -1);
    idle(3);
    chk("empty_writes", wr_cnt - w0, 0);
    chk("empty_done", done_cnt - d0, 1);
    chk("empty_cpu_en", {31'd0, cpu_enable}, 32'd1);

    // Next HI byte lands in the WR cycle and is held for W_H.
    img.delete();
    img.push_back(16'h0001);
    img.push_back(16'h8000);
    d0 = done_cnt;
    send_image(img, 16'h8001, 1, 0, -1);
    idle(3);
    chk("skid_done", done_cnt - d0, 1);
    chk("skid_last_data", {16'd0, last_data}, 32'h8000);

    // Maximum length image: 256 words fill the whole address space.
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(16'(i * 16'h0101) ^ 16'h5A3C);
    begin
      logic [15:0] x;
      x = 16'h0000;
      foreach (img[i]) x = x ^ img[i];
      w0 = wr_cnt; d0 = done_cnt;
      send_image(img, x, 1, -1, -1);
    end
    idle(3);
    chk("max_writes", wr_cnt - w0, 256);
    chk("max_last_addr", {24'd0, last_addr}, 32'hFF);
    chk("max_done", done_cnt - d0, 1);

    // Stall mid-word: the load must abort with no write.
    w0 = wr_cnt;
    send_sync(1);
    send_byte(8'h00, 1);
    send_byte(8'h03, 1);
    send_byte(8'h12, 1);
    idle(10);
    chk("tmo_err_early", {31'd0, load_err}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < TMO + 10 && !seen; i++) begin
      idle(1);
      seen = load_err;
    end
    chk("tmo_err", {31'd0, load_err}, 32'd1);
    chk("tmo_writes", wr_cnt - w0, 0);
    chk("tmo_cpu_en", {31'd0, cpu_enable}, 32'd0);

    // LEN = 257 exceeds 2^ADDR_W.
    w0 = wr_cnt;
    send_sync(1);
    chk("len_err_cleared", {31'd0, load_err}, 32'd0);
    send_byte(8'h01, 1);
    send_byte(8'h01, 1);
    idle(2);
    chk("len_err", {31'd0, load_err}, 32'd1);
    chk("len_writes", wr_cnt - w0, 0);

    // Reset asserted after the third word of a five-word image.
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back(16'h1100 + 16'(i));
    w0 = wr_cnt;
    send_image(img, 16'h0000, 1, -1, 3);
    chk("mid_writes", wr_cnt - w0, 3);
    chk("mid_addr", {24'd0, imem_addr}, 32'h3);
    reset = 1'b0;
    #1;
    chk_all_reset("midrst");
    exp_wr.delete();
    exp_done.delete();
    run_start = INF;
    run_stop  = INF;
    idle(2);
    reset = 1'b1;
    idle(2);
    d0 = done_cnt;
    send_image(img_a, 16'hB9F9, 1, -1, -1);
    idle(3);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_cpu_en", {31'd0, cpu_enable}, 32'd1);

    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_done", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
